// File: rtl/seg7_scan_if.sv
// Display-side bundle between the blanking stage and the seven-segment scan driver.
interface seg7_scan_if;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  dp;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp_n;
    logic        frame_load;

    modport master (
        output data, blank, dp,
        input  an, seg, dp_n, frame_load
    );

    modport slave (
        input  data, blank, dp,
        output an, seg, dp_n, frame_load
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with per-frame
// shadow snapshot and a dark guard interval at the start of every digit slot.
module seg7_scan_driver #(
    parameter int unsigned DIV   = 50000,
    parameter int unsigned GUARD = 64
) (
    input  logic         clk,
    input  logic         rst,
    seg7_scan_if.slave   bus
);
    localparam int unsigned CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_CNT = CNT_W'(GUARD);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [15:0]      sh_data;
    logic [3:0]       sh_blank;
    logic [3:0]       sh_dp;

    logic [3:0]       an_q;
    logic [6:0]       seg_q;
    logic             dp_n_q;
    logic             frame_load_q;

    logic             tick_c;
    logic             load_c;
    logic [3:0]       nib_c;
    logic [6:0]       glyph_c;
    logic [3:0]       an_c;
    logic [6:0]       seg_c;
    logic             dp_n_c;

    assign tick_c = (cnt == CNT_LAST);
    assign load_c = tick_c && (idx == 2'd3);

    // Current digit selection and active-low hex glyph lookup ({g,f,e,d,c,b,a}).
    always_comb begin
        nib_c   = 4'(sh_data >> {idx, 2'b00});
        glyph_c = 7'b1111111;
        case (nib_c)
            4'h0: glyph_c = 7'b1000000;
            4'h1: glyph_c = 7'b1111001;
            4'h2: glyph_c = 7'b0100100;
            4'h3: glyph_c = 7'b0110000;
            4'h4: glyph_c = 7'b0011001;
            4'h5: glyph_c = 7'b0010010;
            4'h6: glyph_c = 7'b0000010;
            4'h7: glyph_c = 7'b1111000;
            4'h8: glyph_c = 7'b0000000;
            4'h9: glyph_c = 7'b0010000;
            4'hA: glyph_c = 7'b0001000;
            4'hB: glyph_c = 7'b0000011;
            4'hC: glyph_c = 7'b1000110;
            4'hD: glyph_c = 7'b0100001;
            4'hE: glyph_c = 7'b0000110;
            4'hF: glyph_c = 7'b0001110;
            default: glyph_c = 7'b1111111;
        endcase
    end

    // Pin values for the next cycle; guard or blanked digit keeps everything dark.
    always_comb begin
        an_c   = 4'b1111;
        seg_c  = 7'b1111111;
        dp_n_c = 1'b1;
        if ((cnt >= GUARD_CNT) && !sh_blank[idx]) begin
            an_c   = ~(4'b0001 << idx);
            seg_c  = glyph_c;
            dp_n_c = ~sh_dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= 2'd0;
            sh_data      <= 16'h0000;
            sh_blank     <= 4'b1111;
            sh_dp        <= 4'b0000;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            dp_n_q       <= 1'b1;
            frame_load_q <= 1'b0;
        end else begin
            cnt          <= tick_c ? '0 : cnt + CNT_W'(1);
            if (tick_c) begin
                idx <= idx + 2'd1;
            end
            // Snapshot at the frame boundary so a frame never mixes old and new values.
            if (load_c) begin
                sh_data  <= bus.data;
                sh_blank <= bus.blank;
                sh_dp    <= bus.dp;
            end
            frame_load_q <= load_c;
            an_q         <= an_c;
            seg_q        <= seg_c;
            dp_n_q       <= dp_n_c;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.frame_load = frame_load_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with DIV=8, GUARD=2 (8-cycle slots, 32-cycle frames).
module tb_seg7_scan_driver;
    localparam int unsigned DIV   = 8;
    localparam int unsigned GUARD = 2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seg7_scan_if bus ();

    seg7_scan_driver #(.DIV(DIV), .GUARD(GUARD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written active-low glyphs, index = hex value.
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    logic [3:0] an_lit [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, " an"},   32'(bus.an),   32'h0000000F);
        chk({tag, " seg"},  32'(bus.seg),  32'h0000007F);
        chk({tag, " dp_n"}, 32'(bus.dp_n), 32'd1);
    endtask

    // Edges 1..32 after reset release: dark, single frame_load at edge 32.
    task automatic startup(input string tag);
        for (int e = 1; e <= 32; e++) begin
            step();
            chk($sformatf("%s e%0d an", tag, e), 32'(bus.an), 32'h0000000F);
            chk($sformatf("%s e%0d fl", tag, e), 32'(bus.frame_load), 32'(e == 32));
        end
    endtask

    // One frame starting right after a load edge; segs = {d3,d2,d1,d0}.
    task automatic check_frame(input string tag, input logic [27:0] segs,
                               input logic [3:0] dark, input logic [3:0] dpn,
                               input int mid_slot, input logic [15:0] mid_data);
        logic       lit;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dpn_e;
        for (int s = 0; s < 4; s++) begin
            if (s == mid_slot) bus.data = mid_data;
            for (int c = 0; c < 8; c++) begin
                step();
                lit   = (c >= 2) && !dark[s];
                an_e  = lit ? an_lit[s] : 4'b1111;
                seg_e = lit ? segs[7*s +: 7] : 7'b1111111;
                dpn_e = lit ? dpn[s] : 1'b1;
                chk($sformatf("%s s%0d c%0d an", tag, s, c),   32'(bus.an),   32'(an_e));
                chk($sformatf("%s s%0d c%0d seg", tag, s, c),  32'(bus.seg),  32'(seg_e));
                chk($sformatf("%s s%0d c%0d dp_n", tag, s, c), 32'(bus.dp_n), 32'(dpn_e));
                chk($sformatf("%s s%0d c%0d fl", tag, s, c),   32'(bus.frame_load),
                    32'((s == 3) && (c == 7)));
                chk($sformatf("%s s%0d c%0d onehot", tag, s, c),
                    32'($countones(~bus.an) <= 1), 32'd1);
            end
        end
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.data  = 16'h1234;
        bus.blank = 4'b0000;
        bus.dp    = 4'b0000;
        step();
        step();
        chk_dark("reset");
        chk("reset fl", 32'(bus.frame_load), 32'd0);
        rst = 1'b0;
        startup("start");

        // Next inputs are staged during the 1234 frame and must not show until the load.
        bus.data  = 16'hFFFF;
        bus.blank = 4'b1010;
        bus.dp    = 4'b0001;
        check_frame("scan", {glyph[1], glyph[2], glyph[3], glyph[4]}, 4'b0000, 4'b1111, -1, 16'h0);

        bus.data  = 16'h0000;
        bus.blank = 4'b0000;
        bus.dp    = 4'b0000;
        check_frame("blankdp", {4{glyph[15]}}, 4'b1010, 4'b1110, -1, 16'h0);

        check_frame("tear0", {4{glyph[0]}}, 4'b0000, 4'b1111, 1, 16'h8888);
        check_frame("tear1", {4{glyph[8]}}, 4'b0000, 4'b1111, -1, 16'h0);

        // Reset in the middle of digit 2's lit window.
        for (int i = 0; i < 19; i++) step();
        chk("mid an", 32'(bus.an), 32'h0000000B);
        rst       = 1'b1;
        bus.data  = 16'h1234;
        step();
        chk_dark("midrst");
        chk("midrst fl", 32'(bus.frame_load), 32'd0);
        rst = 1'b0;
        startup("restart");

        bus.data  = 16'h0000;
        bus.blank = 4'b1110;
        check_frame("rescan", {glyph[1], glyph[2], glyph[3], glyph[4]}, 4'b0000, 4'b1111, -1, 16'h0);

        // Decode sweep on digit 0; the frame checked shows the value staged one frame earlier.
        for (int v = 1; v <= 16; v++) begin
            if (v < 16) bus.data = 16'(v);
            check_frame($sformatf("dec%0h", v - 1), {21'h1FFFFF, glyph[v-1]},
                        4'b1110, 4'b1111, -1, 16'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the calculator's 4-digit common-anode seven-segment display. It sits directly downstream of the per-digit blanking stage. It consumes the 16-bit hex value, the 4-bit per-digit blank mask and the decimal-point mask, snapshots them once per scan frame so the display never tears, and scans one digit at a time. Outputs are active-low anode, segment and decimal-point drives with a guard interval against ghosting.

## Interface
- DIV, 50000: clock cycles per digit slot; legal range GUARD+2 … 2^20.
- GUARD, 64: cycles at the start of each slot during which all anodes are off; must be ≥1.
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  one clock; reset is synchronous and active-high.
- data  in  16  four hex nibbles; [3:0] is digit 0 (rightmost, an[0]), [15:12] is digit 3.
- blank  in  4  per-digit blank mask from the blanking stage; 1 = digit dark.
- dp  in  4  per-digit decimal point; 1 = lit.
- an  out  4  anode enables, active-low.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp_n  out  1  decimal point, active-low.
- frame_load  out  1  one-cycle pulse on the cycle the shadow registers load.

## Operation
- Prescaler cnt counts 0..DIV-1 and wraps. tick = (cnt == DIV-1).
- Digit index idx (2 bits) advances on tick and wraps 3→0.
- Shadow registers sh_data, sh_blank and sh_dp load from the inputs on tick when idx==3, i.e. at the frame boundary. frame_load is registered high on that same edge for exactly one cycle.
- Input changes at any other time have no visible effect until the next load.
- Current digit: nib = sh_data[4*idx+3 : 4*idx], b = sh_blank[idx], p = sh_dp[idx].
- Hex decode (active-low, g..a), standard glyphs:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Output selection:
  - Guard (cnt < GUARD) or blank (b==1): an=1111, seg=1111111, dp_n=1.
  - Otherwise: an = ~(1<<idx), seg = decode(nib), dp_n = ~p.
- Exactly zero or one anode is low at any time, never two.

## Timing
- Reset values:
  - Outputs: an=1111, seg=1111111, dp_n=1, frame_load=0.
  - Internal: cnt=0, idx=0, sh_data=0, sh_blank=1111, sh_dp=0.
- an, seg and dp_n are registered. They reflect the cnt, idx and shadow values present before the same edge, so there is 1 cycle of latency from cnt/idx to pins.
- First shadow load occurs on the 4·DIV-th rising edge after rst deasserts. The display is dark until then.
- Each digit is lit for DIV−GUARD cycles per slot. Frame period is 4·DIV cycles.
- rst asserted mid-frame: every register returns to its reset value on the next edge, regardless of tick, load or idx.
- tick, frame load and idx wrap all occur on the same edge when idx==3. The loaded values are first used for slot 0 of the new frame.
- Inputs need no synchronisation; they are sampled only at the load edge.

## Test plan
- Reset/startup (DIV=8, GUARD=2, data=16'h1234, blank=0, dp=0):
  - an=1111 for edges 1..32 after reset release.
  - frame_load pulses once at edge 32.
  - The next slot shows an=1110, seg=0011001 ("4") for 6 cycles after 2 guard cycles.
- Full scan (same setup):
  - Over one frame, an sequence is 1110→1101→1011→0111.
  - Matching seg sequence is "4","3","2","1" (0011001, 0110000, 0100100, 1111001).
  - an=1111 during each 2-cycle guard.
- Blank/dp (blank=4'b1010, dp=4'b0001, data=16'hFFFF):
  - Digits 1 and 3 stay dark with seg=1111111 and dp_n=1.
  - Digit 0 shows seg=0001110, dp_n=0.
  - Digit 2 shows seg=0001110, dp_n=1.
- Tear-free update: change data from 16'h0000 to 16'h8888 while idx=1.
  - Digits 1..3 of the current frame still show 1000000.
  - All digits show 0000000 only after the next frame_load.
- Mid-operation reset: assert rst for 1 cycle while an=1011.
  - On the next edge: an=1111, seg=1111111, dp_n=1.
  - The startup sequence then repeats exactly.
- Decode sweep: data = each nibble 0..F in digit 0.
  - seg matches the decode list above for all 16 values.
  - At most one an bit is low on every cycle.
